// File: rtl/wb_init_pkg.sv
// rtl/wb_init_pkg.sv - shared types and constants for the Wishbone initiator bridge
package wb_init_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;
    localparam logic [3:0]  WB_SEL_ALL             = 4'hF;
    localparam logic [31:0] ERR_DATA               = 32'h0;

endpackage

// File: rtl/wb_init_timeout.sv
// rtl/wb_init_timeout.sv - clearable ack-less cycle counter with expire flag
module wb_init_timeout
    import wb_init_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned     CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Count enabled cycles since the last clear; the owner leaves BUS on expiry so no wrap handling
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    // Expire on the enabled cycle that would be the TIMEOUT_CYCLES-th one
    assign expire = en && (count == LAST);

endmodule

// File: rtl/wb_initiator_bridge.sv
// rtl/wb_initiator_bridge.sv - single-outstanding Wishbone classic initiator, watchdog under WB_INITIATOR_TIMEOUT_EN
module wb_initiator_bridge
    import wb_init_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [3:0]  cmd_sel,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    state_t state;
    state_t state_next;
    logic   cmd_fire;
    logic   bus_ack;
    logic   expire;

    assign cmd_fire = cmd_valid && (state == IDLE);
    assign bus_ack  = wbm_ack_i && (state == BUS);

    // Handshake flags and bus strobes decode straight from state, so ack never reaches an output combinationally
    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign wbm_cyc_o = (state == BUS);
    assign wbm_stb_o = (state == BUS);

`ifdef WB_INITIATOR_TIMEOUT_EN
    logic rsp_err_q;

    wb_init_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .clr   (cmd_fire),
        .en    ((state == BUS) && !wbm_ack_i),
        .expire(expire)
    );

    // Error flag: set only by an ack-less expiry, cleared by any acknowledged cycle
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rsp_err_q <= 1'b0;
        end else if (bus_ack) begin
            rsp_err_q <= 1'b0;
        end else if (expire) begin
            rsp_err_q <= 1'b1;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign expire  = 1'b0;
    assign rsp_err = 1'b0;
`endif

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: ack takes priority over expiry
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (cmd_valid)              state_next = BUS;
            BUS:  if (wbm_ack_i || expire)    state_next = RESP;
            RESP: if (rsp_ready)              state_next = IDLE;
            default:                          state_next = IDLE;
        endcase
    end

    // Latch the command on acceptance; these registers drive the bus for the whole BUS state
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= 4'h0;
            wbm_adr_o <= 32'h0;
            wbm_dat_o <= 32'h0;
        end else if (cmd_fire) begin
            wbm_we_o  <= cmd_we;
            wbm_sel_o <= cmd_sel;
            wbm_adr_o <= cmd_adr;
            wbm_dat_o <= cmd_dat;
        end
    end

    // Capture read data on ack; writes and aborted cycles return the error pattern
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rsp_dat <= 32'h0;
        end else if (bus_ack) begin
            rsp_dat <= wbm_we_o ? ERR_DATA : wbm_dat_i;
        end else if (expire) begin
            rsp_dat <= ERR_DATA;
        end
    end

endmodule

// File: tb/tb_wb_initiator_bridge.sv
// tb/tb_wb_initiator_bridge.sv - randomized self-checking bench for wb_initiator_bridge
module tb_wb_initiator_bridge;
    import wb_init_pkg::*;

    localparam int unsigned TMO   = 4;
    localparam int          NEVER = 1 << 30;

    logic        wb_clk_i  = 1'b0;
    logic        wb_rst_i  = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we    = 1'b0;
    logic [3:0]  cmd_sel   = 4'h0;
    logic [31:0] cmd_adr   = 32'h0;
    logic [31:0] cmd_dat   = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i = 32'h0;
    logic        wbm_ack_i = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] bus_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    always #5 wb_clk_i = ~wb_clk_i;

    wb_initiator_bridge #(
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_sel  (cmd_sel),
        .cmd_adr  (cmd_adr),
        .cmd_dat  (cmd_dat),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_dat  (rsp_dat),
        .rsp_err  (rsp_err),
        .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o),
        .wbm_we_o (wbm_we_o),
        .wbm_sel_o(wbm_sel_o),
        .wbm_adr_o(wbm_adr_o),
        .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i),
        .wbm_ack_i(wbm_ack_i)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask

    function automatic logic [31:0] fill(input logic [31:0] a);
        return a ^ 32'h5EED_1234;
    endfunction

    function automatic logic [31:0] bus_rd(input logic [31:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : fill(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : fill(a);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    task automatic check_idle_reset_values(input string tag);
        check_eq({tag, "_cmd_ready"}, 32'(cmd_ready), 32'h1);
        check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        check_eq({tag, "_rsp_err"},   32'(rsp_err),   32'h0);
        check_eq({tag, "_rsp_dat"},   rsp_dat,        32'h0);
        check_eq({tag, "_cyc_stb_we"}, 32'({wbm_cyc_o, wbm_stb_o, wbm_we_o}), 32'h0);
        check_eq({tag, "_sel"},       32'(wbm_sel_o), 32'h0);
        check_eq({tag, "_adr"},       wbm_adr_o,      32'h0);
        check_eq({tag, "_dat"},       wbm_dat_o,      32'h0);
    endtask

    // One complete transaction; expectations come from the reference memory and the ack/timeout rule
    task automatic do_txn(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                          input logic [31:0] dat, input int wait_n, input bit no_ack,
                          input int hold_n, input bit keep_valid, output logic [31:0] got_dat);
        int          ack_at;
        int          limit;
        int          bus_len;
        bit          timed_out;
        logic [31:0] exp_dat;

        ack_at = no_ack ? NEVER : wait_n;
`ifdef WB_INITIATOR_TIMEOUT_EN
        limit = int'(TMO);
`else
        limit = NEVER;
`endif
        timed_out = (ack_at + 1 > limit);
        bus_len   = timed_out ? limit : ack_at + 1;
        exp_dat   = (we || timed_out) ? 32'h0 : ref_rd(adr);
        if (we && !timed_out) ref_mem[adr] = merge(ref_rd(adr), dat, sel);

        check_eq("cmd_ready_before", 32'(cmd_ready), 32'h1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_sel   = sel;
        cmd_adr   = adr;
        cmd_dat   = dat;
        step();
        cmd_valid = keep_valid;
        cmd_we    = 1'($urandom);
        cmd_sel   = 4'($urandom);
        cmd_adr   = $urandom;
        cmd_dat   = $urandom;

        for (int c = 0; c < bus_len; c++) begin
            check_eq("bus_cyc_stb", 32'({wbm_cyc_o, wbm_stb_o}), 32'h3);
            check_eq("bus_we_sel", 32'({wbm_we_o, wbm_sel_o}), 32'({we, sel}));
            check_eq("bus_adr", wbm_adr_o, adr);
            if (we) check_eq("bus_dat", wbm_dat_o, dat);
            check_eq("bus_ready_valid", 32'({cmd_ready, rsp_valid}), 32'h0);
            wbm_dat_i = $urandom;
            if (c == ack_at) begin
                wbm_ack_i = 1'b1;
                if (wbm_we_o) bus_mem[wbm_adr_o] = merge(bus_rd(wbm_adr_o), wbm_dat_o, wbm_sel_o);
                else          wbm_dat_i = bus_rd(wbm_adr_o);
            end
            step();
            wbm_ack_i = 1'b0;
            wbm_dat_i = $urandom;
        end

        check_eq("rsp_cyc_low", 32'({wbm_cyc_o, wbm_stb_o}), 32'h0);
        for (int h = 0; h < hold_n; h++) begin
            rsp_ready = 1'b0;
            wbm_ack_i = 1'($urandom);
            check_eq("hold_rsp_valid", 32'(rsp_valid), 32'h1);
            check_eq("hold_rsp_dat", rsp_dat, exp_dat);
            check_eq("hold_rsp_err", 32'(rsp_err), 32'(timed_out));
            check_eq("hold_ready_cyc", 32'({cmd_ready, wbm_cyc_o}), 32'h0);
            step();
        end
        wbm_ack_i = 1'b0;
        check_eq("rsp_valid", 32'(rsp_valid), 32'h1);
        check_eq("rsp_dat", rsp_dat, exp_dat);
        check_eq("rsp_err", 32'(rsp_err), 32'(timed_out));
        got_dat   = rsp_dat;
        rsp_ready = 1'b1;
        cmd_valid = 1'b0;
        step();
        rsp_ready = 1'b0;
        check_eq("after_rsp_ready_valid", 32'({cmd_ready, rsp_valid}), 32'h2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] got;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        bit          no_ack;

        step();
        step();
        check_idle_reset_values("in_reset");
        wb_rst_i = 1'b0;
        step();
        check_idle_reset_values("post_reset");

        do_txn(1'b1, WB_SEL_ALL, 32'h3000_0004, 32'hA5A5_5A5A, 2, 1'b0, 0, 1'b0, got);
        check_eq("write_rsp_zero", got, 32'h0);

        bus_mem[32'h3000_0008] = 32'h1234_5678;
        ref_mem[32'h3000_0008] = 32'h1234_5678;
        do_txn(1'b0, WB_SEL_ALL, 32'h3000_0008, 32'h0, 0, 1'b0, 0, 1'b0, got);
        check_eq("read_const", got, 32'h1234_5678);

        do_txn(1'b0, WB_SEL_ALL, 32'h3000_0004, 32'h0, 1, 1'b0, 5, 1'b1, got);
        check_eq("hold_read_back", got, 32'hA5A5_5A5A);

`ifdef WB_INITIATOR_TIMEOUT_EN
        do_txn(1'b0, WB_SEL_ALL, 32'h3000_0010, 32'h0, 0, 1'b1, 1, 1'b0, got);
        check_eq("timeout_dat", got, 32'h0);
        do_txn(1'b0, WB_SEL_ALL, 32'h3000_0010, 32'h0, int'(TMO) - 1, 1'b0, 0, 1'b0, got);
        check_eq("ack_on_last", got, fill(32'h3000_0010));
`endif

        wbm_ack_i = 1'b1;
        step();
        step();
        check_eq("spurious_ack", 32'({rsp_valid, wbm_cyc_o, cmd_ready}), 32'h1);
        wbm_ack_i = 1'b0;
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_sel   = WB_SEL_ALL;
        cmd_adr   = 32'h3000_0020;
        cmd_dat   = 32'hDEAD_0001;
        step();
        cmd_valid = 1'b0;
        check_eq("pre_reset_cyc", 32'(wbm_cyc_o), 32'h1);
        step();
        wb_rst_i = 1'b1;
        step();
        check_eq("reset_cyc_stb", 32'({wbm_cyc_o, wbm_stb_o}), 32'h0);
        check_eq("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        wb_rst_i = 1'b0;
        step();
        check_idle_reset_values("after_mid_reset");
        step();
        check_eq("no_stale_rsp", 32'(rsp_valid), 32'h0);

        for (int i = 0; i < 4; i++) begin
            adr = 32'h3000_0040 + 32'(4 * i);
            do_txn(1'b0, WB_SEL_ALL, adr, 32'h0, 0, 1'b0, 0, 1'b0, got);
            check_eq("b2b_read", got, fill(adr));
        end

        for (int i = 0; i < 60; i++) begin
            we     = 1'($urandom);
            sel    = 4'($urandom_range(1, 15));
            adr    = 32'h3000_0000 + 32'(4 * $urandom_range(0, 7));
            no_ack = 1'b0;
`ifdef WB_INITIATOR_TIMEOUT_EN
            no_ack = ($urandom_range(0, 7) == 0);
            do_txn(we, sel, adr, $urandom, int'($urandom_range(0, 5)), no_ack,
                   int'($urandom_range(0, 2)), 1'($urandom), got);
`else
            do_txn(we, sel, adr, $urandom, int'($urandom_range(0, 3)), no_ack,
                   int'($urandom_range(0, 2)), 1'($urandom), got);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
